// File: rtl/conv_layer_ctrl.sv
`default_nettype none
//============================================================================
// Module      : conv_layer_ctrl
// Description : Frame sequencer for the shared 1-D convolution engine.
//               For every accepted frame it runs NUM_CH kernels through the
//               engine one at a time, captures the three 24-bit results of
//               each run and streams them downstream with valid/ready.
// Revision    : 1.0 - initial release
//============================================================================
module conv_layer_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_frame_valid,
    output logic            o_frame_ready,
    output logic [CH_W-1:0] o_kern_sel,
    output logic            o_conv_start,
    input  logic            i_conv_finished,
    // Engine output k (k = 0..2) sits at bits [24*k +: 24].
    input  logic [71:0]     i_conv_weights,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [23:0]     o_out_data,
    output logic [CH_W-1:0] o_out_ch,
    output logic [1:0]      o_out_pos,
    output logic            o_out_last,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CH_W-1:0]  c_last_ch  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       c_last_pos = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state_q;
    logic [CH_W-1:0]  r_ch_q;
    logic [1:0]       r_pos_q;
    logic [CNT_W-1:0] r_cnt_q;
    logic [23:0]      r_res_q [3];
    logic             r_err_q;
    logic [23:0]      w_beat_data;

    // Sequencer: frame accept, kernel stepping, engine wait with timeout, beat emission.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= S_IDLE;
            r_ch_q    <= '0;
            r_pos_q   <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_res_q[k] <= '0;
            end
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    // Engine completions are not ours to consume while idle.
                    if (i_frame_valid) begin
                        r_ch_q    <= '0;
                        r_err_q   <= 1'b0;
                        r_state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // One cycle for the kernel ROM to present the selected kernel.
                    r_state_q <= S_START;
                end
                S_START: begin
                    r_cnt_q   <= '0;
                    r_state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_conv_finished) begin
                        for (int k = 0; k < 3; k++) begin
                            r_res_q[k] <= i_conv_weights[24*k +: 24];
                        end
                        r_pos_q   <= '0;
                        r_state_q <= S_EMIT;
                    end else if (r_cnt_q == c_cnt_max) begin
                        // Engine hung: abandon the whole frame, flag it, no done.
                        r_err_q   <= 1'b1;
                        r_state_q <= S_IDLE;
                    end else begin
                        r_cnt_q <= r_cnt_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (i_out_ready) begin
                        if (r_pos_q == c_last_pos) begin
                            if (r_ch_q == c_last_ch) begin
                                r_state_q <= S_DONE;
                            end else begin
                                r_ch_q    <= r_ch_q + 1'b1;
                                r_state_q <= S_LOAD;
                            end
                        end else begin
                            r_pos_q <= r_pos_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state_q <= S_IDLE;
                end
                default: begin
                    r_state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Select the captured result addressed by the beat position.
    always_comb begin
        w_beat_data = '0;
        case (r_pos_q)
            2'd0:    w_beat_data = r_res_q[0];
            2'd1:    w_beat_data = r_res_q[1];
            2'd2:    w_beat_data = r_res_q[2];
            default: w_beat_data = '0;
        endcase
    end

    // All outputs are straight decodes of registered state, so they change
    // only at clock edges and beat fields hold while the sink stalls.
    assign o_frame_ready = (r_state_q == S_IDLE);
    assign o_busy        = (r_state_q != S_IDLE);
    assign o_kern_sel    = r_ch_q;
    assign o_conv_start  = (r_state_q == S_START);
    assign o_out_valid   = (r_state_q == S_EMIT);
    assign o_out_data    = w_beat_data;
    assign o_out_ch      = r_ch_q;
    assign o_out_pos     = r_pos_q;
    assign o_out_last    = (r_state_q == S_EMIT) && (r_pos_q == c_last_pos) &&
                           (r_ch_q == c_last_ch);
    assign o_done        = (r_state_q == S_DONE);
    assign o_err         = r_err_q;

endmodule
`default_nettype wire
